// File: rtl/tdm_demux_4ch_if.sv
// Slot-serial receive bus for the 4-channel TDM demultiplexer.
// The master side drives samples and observes the rebuilt frames; the slave side is the demux.
interface tdm_demux_4ch_if #(
  parameter int DW = 1
);
  logic [DW-1:0]   din;
  logic            din_valid;
  logic            frame_sync;
  logic [4*DW-1:0] dout;
  logic            dout_valid;
  logic [1:0]      slot;
  logic            locked;
  logic            sync_err;

  modport master (
    output din, din_valid, frame_sync,
    input  dout, dout_valid, slot, locked, sync_err
  );

  modport slave (
    input  din, din_valid, frame_sync,
    output dout, dout_valid, slot, locked, sync_err
  );
endinterface

// File: rtl/tdm_demux_4ch.sv
// Four-channel TDM demultiplexer: locks onto frame_sync and rebuilds each
// frame of four slot samples into one parallel word. All outputs are registered.
module tdm_demux_4ch #(
  parameter int DW = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  tdm_demux_4ch_if.slave bus
);

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t             state_r;
  logic [1:0]         slot_r;
  logic [2:0][DW-1:0] shadow_r;
  logic [4*DW-1:0]    dout_r;
  logic               dout_valid_r;
  logic               sync_err_r;

  // Lock FSM, slot tracking, shadow capture and frame output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= HUNT;
      slot_r       <= 2'd0;
      shadow_r     <= '0;
      dout_r       <= '0;
      dout_valid_r <= 1'b0;
      sync_err_r   <= 1'b0;
    end else begin
      dout_valid_r <= 1'b0;
      sync_err_r   <= 1'b0;
      case (state_r)
        HUNT: begin
          if (bus.din_valid && bus.frame_sync) begin
            shadow_r[0] <= bus.din;
            slot_r      <= 2'd1;
            state_r     <= LOCK;
          end
        end
        LOCK: begin
          if (bus.din_valid) begin
            if (bus.frame_sync) begin
              // A sync anywhere but slot 0 drops the partial frame and restarts it,
              // and it wins over completion at slot 3.
              sync_err_r  <= (slot_r != 2'd0);
              shadow_r[0] <= bus.din;
              slot_r      <= 2'd1;
            end else begin
              case (slot_r)
                2'd0: begin
                  sync_err_r <= 1'b1;
                  slot_r     <= 2'd0;
                  state_r    <= HUNT;
                end
                2'd1: begin
                  shadow_r[1] <= bus.din;
                  slot_r      <= 2'd2;
                end
                2'd2: begin
                  shadow_r[2] <= bus.din;
                  slot_r      <= 2'd3;
                end
                default: begin
                  dout_r       <= {bus.din, shadow_r};
                  dout_valid_r <= 1'b1;
                  slot_r       <= 2'd0;
                end
              endcase
            end
          end
        end
        default: begin
          state_r <= HUNT;
          slot_r  <= 2'd0;
        end
      endcase
    end
  end

  assign bus.dout       = dout_r;
  assign bus.dout_valid = dout_valid_r;
  assign bus.slot       = slot_r;
  assign bus.locked     = (state_r == LOCK);
  assign bus.sync_err   = sync_err_r;

endmodule

// File: tb/tb_tdm_demux_4ch.sv
// Self-checking bench: a DW=4 and a DW=1 demux share one stimulus stream;
// expected frames are queued per instance and checked when dout_valid pulses.
module tb_tdm_demux_4ch;

  logic clk;
  logic rst_n;

  tdm_demux_4ch_if #(.DW(4)) b4 ();
  tdm_demux_4ch_if #(.DW(1)) b1 ();

  tdm_demux_4ch #(.DW(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4.slave));
  tdm_demux_4ch #(.DW(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));

  int vectors = 0;
  int errs    = 0;
  int pulses4 = 0;
  int pulses1 = 0;
  logic [15:0] q4[$];
  logic [3:0]  q1[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  // Scoreboard: every dout_valid pulse must match the next queued frame.
  always @(negedge clk) begin
    if (rst_n) begin
      if (b4.dout_valid) begin
        pulses4++;
        vectors++;
        if (q4.size() == 0) begin
          errs++;
          $display("FAIL frame4: unexpected dout_valid, dout=%h, required no frame", b4.dout);
        end else begin
          logic [15:0] e4;
          e4 = q4.pop_front();
          if (b4.dout !== e4) begin
            errs++;
            $display("FAIL frame4: dout=%h required %h", b4.dout, e4);
          end
        end
      end
      if (b1.dout_valid) begin
        pulses1++;
        vectors++;
        if (q1.size() == 0) begin
          errs++;
          $display("FAIL frame1: unexpected dout_valid, dout=%b, required no frame", b1.dout);
        end else begin
          logic [3:0] e1;
          e1 = q1.pop_front();
          if (b1.dout !== e1) begin
            errs++;
            $display("FAIL frame1: dout=%b required %b", b1.dout, e1);
          end
        end
      end
      vectors++;
      if ((b4.dout_valid && b4.sync_err) !== 1'b0) begin
        errs++;
        $display("FAIL excl4: dout_valid and sync_err both high, required exclusive");
      end
    end
  end

  task automatic drive(input logic vl, input logic fs, input logic [3:0] v);
    @(negedge clk);
    b4.din_valid  = vl;
    b4.frame_sync = fs;
    b4.din        = v;
    b1.din_valid  = vl;
    b1.frame_sync = fs;
    b1.din        = v[0];
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 4'h0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    b4.din_valid = 1'b0; b4.frame_sync = 1'b0; b4.din = 4'h0;
    b1.din_valid = 1'b0; b1.frame_sync = 1'b0; b1.din = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({b4.dout, b4.dout_valid, b4.slot, b4.locked, b4.sync_err} !== 21'd0) begin
      errs++;
      $display("FAIL reset4: outputs=%h required 0", {b4.dout, b4.dout_valid, b4.slot, b4.locked, b4.sync_err});
    end
    vectors++;
    if ({b1.dout, b1.dout_valid, b1.slot, b1.locked, b1.sync_err} !== 9'd0) begin
      errs++;
      $display("FAIL reset1: outputs=%h required 0", {b1.dout, b1.dout_valid, b1.slot, b1.locked, b1.sync_err});
    end
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_basic();
    int p4;
    q4.push_back(16'h1101);
    q1.push_back(4'b1101);
    p4 = pulses4;
    drive(1'b1, 1'b1, 4'h1);
    drive(1'b1, 1'b0, 4'h0);
    vectors++;
    if (b4.locked !== 1'b1 || b4.slot !== 2'd1) begin
      errs++;
      $display("FAIL basic_lock: locked=%b slot=%0d required 1 and 1", b4.locked, b4.slot);
    end
    drive(1'b1, 1'b0, 4'h1);
    drive(1'b1, 1'b0, 4'h1);
    idle(1);
    vectors++;
    if (b1.dout !== 4'b1101 || b1.dout_valid !== 1'b1 || b1.locked !== 1'b1 || b1.slot !== 2'd0) begin
      errs++;
      $display("FAIL basic_frame: dout=%b valid=%b locked=%b slot=%0d required 1101 1 1 0",
               b1.dout, b1.dout_valid, b1.locked, b1.slot);
    end
    idle(2);
    vectors++;
    if (pulses4 - p4 !== 1 || b4.dout_valid !== 1'b0) begin
      errs++;
      $display("FAIL basic_pulse: pulses=%0d valid=%b required 1 and 0", pulses4 - p4, b4.dout_valid);
    end
  endtask

  task automatic test_gapped();
    int p4;
    q4.push_back(16'hDCBA);
    q1.push_back(4'b1010);
    p4 = pulses4;
    drive(1'b1, 1'b1, 4'hA);
    drive(1'b0, 1'b1, 4'hF);
    drive(1'b0, 1'b1, 4'hF);
    drive(1'b1, 1'b0, 4'hB);
    idle(2);
    drive(1'b1, 1'b0, 4'hC);
    idle(2);
    vectors++;
    if (b4.slot !== 2'd3 || b4.sync_err !== 1'b0 || b4.dout_valid !== 1'b0) begin
      errs++;
      $display("FAIL gap_slot: slot=%0d sync_err=%b valid=%b required 3 0 0", b4.slot, b4.sync_err, b4.dout_valid);
    end
    drive(1'b1, 1'b0, 4'hD);
    idle(1);
    vectors++;
    if (b4.dout !== 16'hDCBA || b4.dout_valid !== 1'b1) begin
      errs++;
      $display("FAIL gap_frame: dout=%h valid=%b required dcba 1", b4.dout, b4.dout_valid);
    end
    idle(2);
    vectors++;
    if (pulses4 - p4 !== 1) begin
      errs++;
      $display("FAIL gap_pulse: pulses=%0d required 1", pulses4 - p4);
    end
  endtask

  task automatic test_early_sync();
    int p4;
    q4.push_back(16'h8765);
    q1.push_back(4'b0101);
    p4 = pulses4;
    drive(1'b1, 1'b1, 4'h1);
    drive(1'b1, 1'b0, 4'h2);
    drive(1'b1, 1'b1, 4'h5);
    drive(1'b1, 1'b0, 4'h6);
    vectors++;
    if (b4.sync_err !== 1'b1 || b1.sync_err !== 1'b1 || b4.dout_valid !== 1'b0 ||
        b4.slot !== 2'd1 || b4.locked !== 1'b1) begin
      errs++;
      $display("FAIL early_err: sync_err=%b/%b valid=%b slot=%0d locked=%b required 1/1 0 1 1",
               b4.sync_err, b1.sync_err, b4.dout_valid, b4.slot, b4.locked);
    end
    drive(1'b1, 1'b0, 4'h7);
    vectors++;
    if (b4.sync_err !== 1'b0) begin
      errs++;
      $display("FAIL early_once: sync_err=%b required 0", b4.sync_err);
    end
    drive(1'b1, 1'b0, 4'h8);
    idle(1);
    vectors++;
    if (b4.dout !== 16'h8765 || b4.dout_valid !== 1'b1) begin
      errs++;
      $display("FAIL early_frame: dout=%h valid=%b required 8765 1", b4.dout, b4.dout_valid);
    end
    idle(1);
    vectors++;
    if (pulses4 - p4 !== 1) begin
      errs++;
      $display("FAIL early_pulse: pulses=%0d required 1", pulses4 - p4);
    end
  endtask

  task automatic test_missing_sync();
    q4.push_back(16'h4321);
    q1.push_back(4'b0101);
    drive(1'b1, 1'b1, 4'h1);
    drive(1'b1, 1'b0, 4'h2);
    drive(1'b1, 1'b0, 4'h3);
    drive(1'b1, 1'b0, 4'h4);
    drive(1'b1, 1'b0, 4'h9);
    drive(1'b1, 1'b0, 4'hE);
    vectors++;
    if (b1.sync_err !== 1'b1 || b1.locked !== 1'b0 || b1.dout !== 4'b0101 ||
        b4.dout !== 16'h4321 || b4.slot !== 2'd0 || b4.dout_valid !== 1'b0) begin
      errs++;
      $display("FAIL missing_err: sync_err=%b locked=%b dout1=%b dout4=%h slot=%0d valid=%b required 1 0 0101 4321 0 0",
               b1.sync_err, b1.locked, b1.dout, b4.dout, b4.slot, b4.dout_valid);
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 4'(i + 3));
      vectors++;
      if (b4.sync_err !== 1'b0 || b4.locked !== 1'b0 || b1.sync_err !== 1'b0) begin
        errs++;
        $display("FAIL missing_hunt: sync_err=%b/%b locked=%b required 0/0 0", b4.sync_err, b1.sync_err, b4.locked);
      end
    end
    idle(2);
  endtask

  task automatic test_reset_mid();
    int p4;
    drive(1'b1, 1'b1, 4'h1);
    drive(1'b1, 1'b0, 4'h2);
    @(negedge clk);
    b4.din_valid = 1'b0; b1.din_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({b4.dout, b4.dout_valid, b4.slot, b4.locked, b4.sync_err} !== 21'd0 ||
        {b1.dout, b1.dout_valid, b1.slot, b1.locked, b1.sync_err} !== 9'd0) begin
      errs++;
      $display("FAIL reset_mid: outputs4=%h outputs1=%h required 0",
               {b4.dout, b4.dout_valid, b4.slot, b4.locked, b4.sync_err},
               {b1.dout, b1.dout_valid, b1.slot, b1.locked, b1.sync_err});
    end
    @(negedge clk);
    rst_n = 1'b1;
    p4 = pulses4;
    for (int i = 3; i < 7; i++) drive(1'b1, 1'b0, 4'(i));
    idle(2);
    vectors++;
    if (pulses4 - p4 !== 0 || b4.locked !== 1'b0 || b4.dout !== 16'h0) begin
      errs++;
      $display("FAIL reset_resume: pulses=%0d locked=%b dout=%h required 0 0 0", pulses4 - p4, b4.locked, b4.dout);
    end
  endtask

  task automatic test_back_to_back();
    q4.push_back(16'h4321);
    q4.push_back(16'h8765);
    q1.push_back(4'b0101);
    q1.push_back(4'b0101);
    drive(1'b1, 1'b1, 4'h1);
    drive(1'b1, 1'b0, 4'h2);
    drive(1'b1, 1'b0, 4'h3);
    drive(1'b1, 1'b0, 4'h4);
    drive(1'b1, 1'b1, 4'h5);
    vectors++;
    if (b4.dout !== 16'h4321 || b4.dout_valid !== 1'b1) begin
      errs++;
      $display("FAIL b2b_first: dout=%h valid=%b required 4321 1", b4.dout, b4.dout_valid);
    end
    drive(1'b1, 1'b0, 4'h6);
    drive(1'b1, 1'b0, 4'h7);
    vectors++;
    if (b4.dout_valid !== 1'b0 || b4.dout !== 16'h4321) begin
      errs++;
      $display("FAIL b2b_hold: dout=%h valid=%b required 4321 0", b4.dout, b4.dout_valid);
    end
    drive(1'b1, 1'b0, 4'h8);
    idle(1);
    vectors++;
    if (b4.dout !== 16'h8765 || b4.dout_valid !== 1'b1 || b4.sync_err !== 1'b0) begin
      errs++;
      $display("FAIL b2b_second: dout=%h valid=%b sync_err=%b required 8765 1 0", b4.dout, b4.dout_valid, b4.sync_err);
    end
    idle(2);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gapped();
    test_early_sync();
    test_missing_sync();
    test_reset_mid();
    test_back_to_back();
    idle(2);
    vectors++;
    if (q4.size() !== 0 || q1.size() !== 0) begin
      errs++;
      $display("FAIL drain: pending frames %0d/%0d required 0/0", q4.size(), q1.size());
    end
    vectors++;
    if (pulses1 !== pulses4) begin
      errs++;
      $display("FAIL pulse_match: dw1 pulses=%0d required %0d", pulses1, pulses4);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
